iter_div: RTL and testbench
===========================

ITER_DIV -- requirements
Module: iter_div

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand/result width; legal values are even integers 4..64.
REQ-002 The block SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-003 The block SHALL have port clr  input  1  asynchronous, active-low reset.
REQ-004 The block SHALL have port start_i  input  1  request a divide; sampled only in IDLE.
REQ-005 The block SHALL have port annul_i  input  1  abort the operation in flight (pipeline flush).
REQ-006 The block SHALL have port signed_i  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start_i.
REQ-007 The block SHALL have port dividend_i  input  WIDTH  dividend, sampled with start_i.
REQ-008 The block SHALL have port divisor_i  input  WIDTH  divisor, sampled with start_i.
REQ-009 The block SHALL have port busy_o  output  1  stall request to the pipeline controller.
REQ-010 The block SHALL have port ready_o  output  1  one-cycle result-valid pulse.
REQ-011 The block SHALL have port quotient_o  output  WIDTH  quotient, held until next result.
REQ-012 The block SHALL have port remainder_o  output  WIDTH  remainder, held until next result.
REQ-013 The block SHALL have port div_zero_o  output  1  last result was divide-by-zero, held with the result.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, BYZERO, ON and END.
REQ-015 In IDLE, when start_i=1 and annul_i=0, the FSM SHALL latch the operands and go to BYZERO if divisor_i==0, else to ON with iteration counter 0.
REQ-016 In IDLE, when start_i=1 and annul_i=1 in the same cycle, annul SHALL win and no operation SHALL start.
REQ-017 In ON, the block SHALL perform one restoring shift-subtract iteration per cycle and go to END after the last iteration; the base iteration count SHALL be WIDTH.
REQ-018 BYZERO SHALL last one cycle, then go to END with quotient 0, remainder 0 and div_zero_o=1.
REQ-019 In END, ready_o SHALL be 1 and quotient_o/remainder_o/div_zero_o SHALL carry the new result; the FSM SHALL return to IDLE on the next edge; ready_o SHALL be 0 in all other states.
REQ-020 busy_o SHALL be 1 when (IDLE and start_i and not annul_i), or in BYZERO, or in ON; it SHALL be 0 in END.
REQ-021 The base latency SHALL be WIDTH+1 cycles from the start edge to the END cycle; divide-by-zero latency SHALL be 2.
REQ-022 Signed mode: operands SHALL be converted to magnitudes at start; the quotient SHALL be negated when the operand signs differ; the remainder SHALL take the dividend's sign.
REQ-023 Signed most-negative / -1 SHALL give quotient = most-negative value (wraps) and remainder 0.
REQ-024 A start_i asserted outside IDLE SHALL be ignored.
REQ-025 annul_i=1 in BYZERO or ON SHALL return the FSM to IDLE on the next edge; no ready_o pulse SHALL occur and result outputs SHALL keep their previous values.
REQ-026 annul_i in END SHALL have no effect; the result SHALL still be delivered.

Reset
REQ-027 On clr=0, the FSM SHALL enter IDLE immediately, independent of clk, and all outputs, the counter and the datapath registers SHALL be 0.
REQ-028 A reset during ON SHALL discard the operation; after release, the block SHALL accept a new start normally.

Configuration
REQ-029 The feature SHALL be controlled by macro ITER_DIV_EARLY_TERM_EN.
REQ-030 When ITER_DIV_EARLY_TERM_EN is defined, at start the dividend magnitude SHALL be pre-shifted left by its leading-zero count lz, and ON SHALL last max(WIDTH-lz, 1) cycles; results SHALL be identical to the base mode.
REQ-031 When ITER_DIV_EARLY_TERM_EN is undefined, ON SHALL always last WIDTH cycles and no leading-zero logic SHALL be present.

Structure
REQ-032 The state encodings (2 bits) and the div-zero result constants SHALL live in the shared defines header alongside the existing pipeline constants.
REQ-033 A single sub-module, lzc (parametrised leading-zero counter, WIDTH input, clog2(WIDTH)+1 output), SHALL be instantiated only under ITER_DIV_EARLY_TERM_EN.
REQ-034 busy_o SHALL connect as a stall source to the pipeline ctrl; annul_i SHALL be driven by the flush/branch-cancel logic.

Verification
REQ-035 WIDTH=32, unsigned 100/7, start at cycle 0 -> ready_o at cycle 33, q=14, r=2; with EARLY_TERM (lz=25) -> ready_o at cycle 8, same q/r.
REQ-036 Signed -7/2 -> q=0xFFFFFFFD, r=0xFFFFFFFF; signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0.
REQ-037 Divisor 0 -> ready_o at cycle 2, div_zero_o=1, q=0, r=0, busy_o=1 in cycles 0-1.
REQ-038 annul_i at cycle 10 of an operation -> IDLE at cycle 11, no ready_o, outputs unchanged; a start_i at cycle 5 of that operation has no effect.
REQ-039 clr low at cycle 5 mid-divide -> all outputs 0 asynchronously; after release, WIDTH=8 unsigned 200/3 -> q=66, r=2, ready_o at cycle 9.

Source files
------------

// File: rtl/iter_div_pkg.sv
// iter_div_pkg: FSM state encodings and divide-by-zero result constants shared by the iterative divider.
package iter_div_pkg;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BYZERO = 2'd1,
      ON     = 2'd2,
      END    = 2'd3
   } state_t;
   localparam logic        DZ_FLAG      = 1'b1;
   localparam logic [63:0] DZ_QUOTIENT  = 64'd0;
   localparam logic [63:0] DZ_REMAINDER = 64'd0;
endpackage

// File: rtl/iter_div_if.sv
// iter_div_if: request/result bundle between the pipeline and the iterative divider.
interface iter_div_if #(parameter int WIDTH = 32);
   logic             start_i;
   logic             annul_i;
   logic             signed_i;
   logic [WIDTH-1:0] dividend_i;
   logic [WIDTH-1:0] divisor_i;
   logic             busy_o;
   logic             ready_o;
   logic [WIDTH-1:0] quotient_o;
   logic [WIDTH-1:0] remainder_o;
   logic             div_zero_o;
   modport master (
      output start_i, annul_i, signed_i, dividend_i, divisor_i,
      input  busy_o, ready_o, quotient_o, remainder_o, div_zero_o
   );
   modport slave (
      input  start_i, annul_i, signed_i, dividend_i, divisor_i,
      output busy_o, ready_o, quotient_o, remainder_o, div_zero_o
   );
endinterface

// File: rtl/iter_div_lzc.sv
// lzc: leading-zero counter; an all-zero input reports WIDTH.
module lzc #(parameter int WIDTH = 32) (
   input  logic [WIDTH-1:0]         a,
   output logic [$clog2(WIDTH):0]   lz
);
   always_comb begin
      lz = ($clog2(WIDTH)+1)'(WIDTH);
      for (int i = 0; i < WIDTH; i++)
         if (a[i]) lz = ($clog2(WIDTH)+1)'(WIDTH - 1 - i);
   end
endmodule

// File: rtl/iter_div.sv
// iter_div: restoring shift-subtract divider, one quotient bit per cycle, signed/unsigned, annul and div-by-zero.
// Define ITER_DIV_EARLY_TERM_EN to skip the dividend's leading zeros and shorten the ON phase.
module iter_div
   import iter_div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input logic     clk,
   input logic     clr,
   iter_div_if.slave bus
);
   localparam int             CW       = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0]  LAST_MAX = CW'(WIDTH - 1);

   state_t           state, state_nx;
   logic             go, a_neg, b_neg, load, busy, ready;
   logic             neg_q, neg_r, dz_q;
   logic [WIDTH-1:0] mag_a, mag_b, acc_ld, rem_nx, acc_nx;
   logic [WIDTH-1:0] rem_q, acc_q, dvs_q, quo_q, res_r_q;
   logic [WIDTH:0]   rem_sh, diff;
   logic [CW-1:0]    cnt_q, last_q, last_ld;

   assign go    = bus.start_i & ~bus.annul_i;
   assign a_neg = bus.signed_i & bus.dividend_i[WIDTH-1];
   assign b_neg = bus.signed_i & bus.divisor_i[WIDTH-1];
   assign mag_a = a_neg ? -bus.dividend_i : bus.dividend_i;
   assign mag_b = b_neg ? -bus.divisor_i : bus.divisor_i;

`ifdef ITER_DIV_EARLY_TERM_EN
   logic [CW-1:0] lz;
   lzc #(.WIDTH(WIDTH)) u_lzc (.a(mag_a), .lz(lz));
   // Leading zeros never produce quotient bits, so shift them out before iterating.
   assign acc_ld  = mag_a << lz;
   assign last_ld = (lz == CW'(WIDTH)) ? '0 : LAST_MAX - lz;
`else
   assign acc_ld  = mag_a;
   assign last_ld = LAST_MAX;
`endif

   assign rem_sh = {rem_q, acc_q[WIDTH-1]};
   assign diff   = rem_sh - {1'b0, dvs_q};
   assign rem_nx = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
   assign acc_nx = {acc_q[WIDTH-2:0], ~diff[WIDTH]};

   always_ff @(posedge clk or negedge clr)
      if (!clr) state <= IDLE;
      else      state <= state_nx;

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      ready    = 1'b0;
      load     = 1'b0;
      case (state)
         IDLE:    state_nx = go ? ((bus.divisor_i == '0) ? BYZERO : ON) : IDLE;
         BYZERO:  state_nx = bus.annul_i ? IDLE : END;
         ON:      state_nx = bus.annul_i ? IDLE : ((cnt_q == last_q) ? END : ON);
         default: state_nx = IDLE;
      endcase
      busy  = clr & (((state == IDLE) & go) | (state == BYZERO) | (state == ON));
      ready = state == END;
      load  = (state != END) & (state_nx == END);
   end

   always_ff @(posedge clk or negedge clr)
      if (!clr) begin
         rem_q   <= '0;
         acc_q   <= '0;
         dvs_q   <= '0;
         cnt_q   <= '0;
         last_q  <= '0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         quo_q   <= '0;
         res_r_q <= '0;
         dz_q    <= 1'b0;
      end else begin
         if (state == IDLE && go) begin
            rem_q  <= '0;
            acc_q  <= acc_ld;
            dvs_q  <= mag_b;
            cnt_q  <= '0;
            last_q <= last_ld;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
         end
         if (state == ON) begin
            rem_q <= rem_nx;
            acc_q <= acc_nx;
            cnt_q <= cnt_q + 1'b1;
         end
         if (load) begin
            quo_q   <= (state == BYZERO) ? DZ_QUOTIENT[WIDTH-1:0] : (neg_q ? -acc_nx : acc_nx);
            res_r_q <= (state == BYZERO) ? DZ_REMAINDER[WIDTH-1:0] : (neg_r ? -rem_nx : rem_nx);
            dz_q    <= (state == BYZERO) ? DZ_FLAG : 1'b0;
         end
      end

   assign bus.busy_o      = busy;
   assign bus.ready_o     = ready;
   assign bus.quotient_o  = quo_q;
   assign bus.remainder_o = res_r_q;
   assign bus.div_zero_o  = dz_q;
endmodule

// File: tb/tb_iter_div.sv
// tb_iter_div: directed vector table plus annul/reset sequences on a 32-bit and an 8-bit divider.
module tb_iter_div;
   logic clk = 1'b0;
   logic clr;
   int   n_chk  = 0;
   int   n_fail = 0;
   logic        s_busy, s_rdy, s_dz;
   logic [31:0] s_q, s_r;

   always #5 clk = ~clk;

   iter_div_if #(.WIDTH(32)) bus32 ();
   iter_div_if #(.WIDTH(8))  bus8 ();
   iter_div #(.WIDTH(32)) dut32 (.clk(clk), .clr(clr), .bus(bus32));
   iter_div #(.WIDTH(8))  dut8  (.clk(clk), .clr(clr), .bus(bus8));

   typedef struct {
      bit          sg;
      logic [31:0] a, b, q, r;
      bit          dz;
   } vec_t;
   vec_t vecs[14];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input bit w8, input bit st, input bit an, input bit sg, input logic [31:0] a, input logic [31:0] b);
      if (w8) begin
         bus8.start_i = st; bus8.annul_i = an; bus8.signed_i = sg;
         bus8.dividend_i = a[7:0]; bus8.divisor_i = b[7:0];
      end else begin
         bus32.start_i = st; bus32.annul_i = an; bus32.signed_i = sg;
         bus32.dividend_i = a; bus32.divisor_i = b;
      end
   endtask

   task automatic sample(input bit w8);
      if (w8) begin
         s_busy = bus8.busy_o; s_rdy = bus8.ready_o; s_dz = bus8.div_zero_o;
         s_q = {24'd0, bus8.quotient_o}; s_r = {24'd0, bus8.remainder_o};
      end else begin
         s_busy = bus32.busy_o; s_rdy = bus32.ready_o; s_dz = bus32.div_zero_o;
         s_q = bus32.quotient_o; s_r = bus32.remainder_o;
      end
   endtask

   function automatic int exp_lat(input bit w8, input bit sg, input logic [31:0] a, input logic [31:0] b);
      int          w;
      logic [31:0] mask, m;
      int          lz;
      w    = w8 ? 8 : 32;
      mask = w8 ? 32'hFF : 32'hFFFF_FFFF;
      if ((b & mask) == 32'd0) return 2;
      m  = a & mask;
      if (sg && m[w-1]) m = (-m) & mask;
      lz = w;
      for (int i = 0; i < w; i++) if (m[i]) lz = w - 1 - i;
`ifdef ITER_DIV_EARLY_TERM_EN
      return ((w - lz) < 1 ? 1 : w - lz) + 1;
`else
      return (lz >= 0) ? w + 1 : 0;
`endif
   endfunction

   task automatic run(input string tag, input bit w8, input bit sg, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] q, input logic [31:0] r, input bit dz, input bit an_end, input bit mid_start);
      int lat, n;
      lat = exp_lat(w8, sg, a, b);
      @(negedge clk);
      drive(w8, 1'b1, 1'b0, sg, a, b);
      #1 sample(w8);
      chk({tag, ".busy_start"}, 64'(s_busy), 64'd1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         drive(w8, mid_start && n == 5, an_end && n == lat, sg, (n == 5) ? 32'd50 : a, (n == 5) ? 32'd5 : b);
         #1 sample(w8);
      end while (!s_rdy && n < 200);
      chk({tag, ".latency"}, 64'(n), 64'(lat));
      chk({tag, ".quotient"}, 64'(s_q), 64'(q));
      chk({tag, ".remainder"}, 64'(s_r), 64'(r));
      chk({tag, ".div_zero"}, 64'(s_dz), 64'(dz));
      chk({tag, ".busy_end"}, 64'(s_busy), 64'd0);
      @(negedge clk);
      drive(w8, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      #1 sample(w8);
      chk({tag, ".ready_pulse"}, 64'(s_rdy), 64'd0);
   endtask

   initial begin
      int pulses;
      vecs[0]  = '{0, 32'd100,        32'd7,          32'd14,         32'd2,          0};
      vecs[1]  = '{1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  0};
      vecs[2]  = '{1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          0};
      vecs[3]  = '{0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          0};
      vecs[4]  = '{0, 32'd5,          32'd10,         32'd0,          32'd5,          0};
      vecs[5]  = '{0, 32'd0,          32'd3,          32'd0,          32'd0,          0};
      vecs[6]  = '{1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          0};
      vecs[7]  = '{1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  0};
      vecs[8]  = '{0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          0};
      vecs[9]  = '{0, 32'd12345,      32'd0,          32'd0,          32'd0,          1};
      vecs[10] = '{1, 32'hFFFF_FFFB,  32'd0,          32'd0,          32'd0,          1};
      vecs[11] = '{0, 32'h8000_0000,  32'd3,          32'h2AAA_AAAA,  32'd2,          0};
      vecs[12] = '{1, 32'h8000_0000,  32'd2,          32'hC000_0000,  32'd0,          0};
      vecs[13] = '{0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          0};

      clr = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      #2;
      sample(0);
      chk("reset32.ctrl", {61'd0, s_busy, s_rdy, s_dz}, 64'd0);
      sample(1);
      chk("reset8.ctrl", {61'd0, s_busy, s_rdy, s_dz}, 64'd0);
      @(negedge clk) clr = 1'b1;

      for (int i = 0; i < 14; i++)
         run($sformatf("vec%0d", i), 1'b0, vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dz, 1'b0, 1'b0);

      run("mid_start", 1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 1'b1);

      @(negedge clk);
      drive(0, 1, 0, 0, 32'hFFFF_0000, 32'd7);
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         drive(0, c == 5, c == 10, 0, (c == 5) ? 32'd50 : 32'd0, (c == 5) ? 32'd5 : 32'd0);
         #1 sample(0);
         if (c == 10) chk("annul.busy_on", 64'(s_busy), 64'd1);
      end
      chk("annul.idle", {62'd0, s_busy, s_rdy}, 64'd0);
      chk("annul.q_held", 64'(s_q), 64'd14);
      chk("annul.r_held", 64'(s_r), 64'd2);
      chk("annul.dz_held", 64'(s_dz), 64'd0);
      pulses = 0;
      repeat (40) begin
         @(negedge clk);
         #1 if (bus32.ready_o) pulses++;
      end
      chk("annul.no_ready", 64'(pulses), 64'd0);

      @(negedge clk);
      drive(0, 1, 1, 0, 32'd100, 32'd7);
      #1 sample(0);
      chk("start_annul.busy", 64'(s_busy), 64'd0);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0);
      #1 sample(0);
      chk("start_annul.idle", {62'd0, s_busy, s_rdy}, 64'd0);

      @(negedge clk);
      drive(0, 1, 0, 0, 32'd9, 32'd0);
      @(negedge clk);
      drive(0, 0, 1, 0, 0, 0);
      #1 sample(0);
      chk("annul_byzero.busy", 64'(s_busy), 64'd1);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0);
      #1 sample(0);
      chk("annul_byzero.ctrl", {61'd0, s_busy, s_rdy, s_dz}, 64'd0);
      chk("annul_byzero.q_held", 64'(s_q), 64'd14);
      @(negedge clk);
      #1 sample(0);
      chk("annul_byzero.no_ready", 64'(s_rdy), 64'd0);

      run("w8_pre", 1'b1, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0);

      @(negedge clk);
      drive(0, 1, 0, 0, 32'hFFFF_0000, 32'd7);
      drive(1, 1, 0, 0, 32'd200, 32'd3);
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         drive(0, 0, 0, 0, 0, 0);
         drive(1, 0, 0, 0, 0, 0);
      end
      #2 clr = 1'b0;
      #1 sample(0);
      chk("midreset32.ctrl", {61'd0, s_busy, s_rdy, s_dz}, 64'd0);
      chk("midreset32.q", 64'(s_q), 64'd0);
      chk("midreset32.r", 64'(s_r), 64'd0);
      sample(1);
      chk("midreset8.ctrl", {61'd0, s_busy, s_rdy, s_dz}, 64'd0);
      chk("midreset8.q", 64'(s_q), 64'd0);
      chk("midreset8.r", 64'(s_r), 64'd0);
      @(negedge clk) clr = 1'b1;

      run("w8_post", 1'b1, 1'b0, 32'd200, 32'd3, 32'd66, 32'd2, 1'b0, 1'b1, 1'b0);
      run("w8_signed", 1'b1, 1'b1, 32'hF9, 32'd2, 32'hFD, 32'hFF, 1'b0, 1'b0, 1'b0);
      run("w32_post", 1'b0, 1'b0, 32'hFFFF_0000, 32'd7, 32'h2492_2492, 32'd2, 1'b0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
